// File: rtl/decoder_rr_arbiter_if.sv
// decoder_rr_arbiter_if: request/grant bundle between requesters (master) and the arbiter (slave).
interface decoder_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    modport master (output en, req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input en, req, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin owner of a 3-to-8 decoded resource with one dead cycle between owners.
// Optional hold limit of MAX_HOLD cycles when ARB_HOLD_LIMIT_EN is defined.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_e;
    state_e     state_q;
    logic [7:0] gnt_q, cnt_q;
    logic [2:0] idx_q, ptr_q, win_d;
    logic       valid_q, hold_d, rel_d;
    // Scan from farthest offset to nearest so the last hit is the closest to ptr.
    always_comb begin
        win_d = ptr_q;
        for (int k = 7; k >= 0; k--)
            if (bus.req[ptr_q + 3'(k)]) win_d = ptr_q + 3'(k);
    end
`ifdef ARB_HOLD_LIMIT_EN
    assign hold_d = cnt_q == 8'(MAX_HOLD);
`else
    assign hold_d = 1'b0;
`endif
    assign rel_d = !bus.req[idx_q] || !bus.en || hold_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
        end else if (state_q == IDLE) begin
            if (bus.en && |bus.req) begin
                state_q <= GRANT;
                idx_q   <= win_d;
                gnt_q   <= 8'd1 << win_d;
                valid_q <= 1'b1;
                cnt_q   <= 8'd1;
            end
        end else if (rel_d) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + 3'd1;
            cnt_q   <= 8'd0;
        end else begin
            cnt_q <= cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
        end
    end
    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed checks of reset, round-robin order, hold limit, enable and reset aborts.
module tb_decoder_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    decoder_rr_arbiter_if bif ();
    decoder_rr_arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_g(input string tag, input logic [7:0] g, input logic [2:0] idx);
        chk({tag, ".gnt"}, bif.gnt, g);
        chk({tag, ".valid"}, {7'd0, bif.gnt_valid}, {7'd0, |g});
        chk({tag, ".idx"}, {5'd0, bif.gnt_idx}, {5'd0, idx});
    endtask

    initial begin
        logic [7:0] e;
        rst_n = 1'b0; bif.en = 1'b0; bif.req = 8'hFF;
        cyc(); cyc();
        exp_g("reset", 8'h00, 3'd0);
        rst_n = 1'b1;
        cyc(); exp_g("en_low0", 8'h00, 3'd0);
        cyc(); exp_g("en_low1", 8'h00, 3'd0);
        bif.en = 1'b1; bif.req = 8'h20;
        cyc(); exp_g("single", 8'h20, 3'd5);
        bif.req = 8'h00;
        cyc(); exp_g("single_rel", 8'h00, 3'd5);
        bif.req = 8'h41;
        cyc(); exp_g("ptr6", 8'h40, 3'd6);
        bif.req = 8'h00;
        cyc(); exp_g("ptr6_rel", 8'h00, 3'd6);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = 8'd1 << (i % 8);
            bif.req = 8'hFF;
            for (int c = 0; c < 3; c++) begin
                cyc(); exp_g($sformatf("rr%0d_%0d", i, c), e, 3'(i % 8));
            end
            bif.req = 8'hFF & ~e;
            cyc(); exp_g($sformatf("rr%0d_dead", i), 8'h00, 3'(i % 8));
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; bif.req = 8'h09;
`ifdef ARB_HOLD_LIMIT_EN
        for (int c = 0; c < 4; c++) begin cyc(); exp_g($sformatf("hold0_%0d", c), 8'h01, 3'd0); end
        cyc(); exp_g("hold_dead0", 8'h00, 3'd0);
        for (int c = 0; c < 4; c++) begin cyc(); exp_g($sformatf("hold3_%0d", c), 8'h08, 3'd3); end
        cyc(); exp_g("hold_dead1", 8'h00, 3'd3);
        cyc(); exp_g("hold_back0", 8'h01, 3'd0);
`else
        for (int c = 0; c < 10; c++) begin cyc(); exp_g($sformatf("nohold_%0d", c), 8'h01, 3'd0); end
`endif
        bif.req = 8'h00;
        cyc(); exp_g("hold_rel", 8'h00, 3'd0);
        bif.req = 8'h04;
        cyc(); exp_g("en_own2", 8'h04, 3'd2);
        bif.en = 1'b0;
        cyc(); exp_g("en_off0", 8'h00, 3'd2);
        cyc(); exp_g("en_off1", 8'h00, 3'd2);
        cyc(); exp_g("en_off2", 8'h00, 3'd2);
        bif.en = 1'b1; bif.req = 8'h0C;
        cyc(); exp_g("en_on_pri3", 8'h08, 3'd3);
        bif.req = 8'h04;
        cyc(); exp_g("pri3_rel", 8'h00, 3'd3);
        cyc(); exp_g("wrap2", 8'h04, 3'd2);
        bif.req = 8'h80;
        cyc(); exp_g("own2_rel", 8'h00, 3'd2);
        cyc(); exp_g("own7", 8'h80, 3'd7);
        rst_n = 1'b0;
        cyc(); exp_g("rst_mid", 8'h00, 3'd0);
        rst_n = 1'b1; bif.req = 8'h81;
        cyc(); exp_g("post_rst", 8'h01, 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
